rx_packet_parser: RTL and testbench

Framing stage directly downstream of the UART receiver (`rxModule`). Consumes each received byte (`rx_data` qualified by `rx_done_sig`), hunts for a header, and assembles command frames: header, command, length, payload, XOR checksum. Validated frames are held in a payload buffer and offered to the command logic with a valid/ready handshake. While a frame is held, the receiver is back-pressured through `rx_en_sig`.

---
 rtl/rx_pkt_pkg.sv | 27 ++
 rtl/rx_pkt_buffer.sv | 35 +++
 rtl/rx_packet_parser.sv | 213 +++++++++++++++++++++
 tb/tb_rx_packet_parser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the rx_packet_parser framing stage:
// parser state encoding, error cause codes, default start-of-frame byte
// and the checksum accumulate helper.
package rx_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    CMD  = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    HOLD = 3'd5
  } rx_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  // One step of the 8-bit XOR frame checksum.
  function automatic logic [7:0] chk_xor(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/rx_pkt_buffer.sv
// Payload store for rx_packet_parser: DEPTH x 8 register file with one
// synchronous write port and one asynchronous read port. Not reset; reads
// beyond DEPTH (non power-of-two depths) return zero.
module rx_pkt_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write one payload byte per enabled cycle.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read with out-of-range guard.
  always_comb begin
    rdata = 8'h00;
    if (int'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end else begin
      rdata = 8'h00;
    end
  end

endmodule

// File: rtl/rx_packet_parser.sv
// Frame parser behind the UART receiver: hunts for HEADER, collects
// command, length, payload and XOR checksum, then holds a validated frame
// for the consumer while back-pressuring the receiver.
// Optional inter-byte timeout is built when RX_PKT_TIMEOUT_EN is defined.
module rx_packet_parser
  import rx_pkt_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYCLES = 50000,
  localparam int        LW             = $clog2(MAX_LEN + 1),
  localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rx_data,
  input  logic          rx_done_sig,
  output logic          rx_en_sig,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [7:0]    pkt_cmd,
  output logic [LW-1:0] pkt_len,
  input  logic [AW-1:0] pkt_rd_addr,
  output logic [7:0]    pkt_rd_data,
  output logic          err_sig,
  output logic [1:0]    err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  rx_state_e     state;
  rx_state_e     state_next;
  logic          done_q;
  logic          stb;
  logic [7:0]    cmd;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [7:0]    chk;
  logic          err_fire;
  logic [1:0]    err_next;
  logic          tmo_hit;
  logic          valid_q;
  logic          rx_en_q;
  logic          err_sig_q;
  logic [1:0]    err_code_q;
  logic          buf_we;

  // Rising edge of the receiver done level marks one new byte.
  assign stb    = rx_done_sig & ~done_q;
  assign buf_we = stb && (state == DATA);

`ifdef RX_PKT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timer;
  logic          counting;

  assign counting = (state == CMD) || (state == LEN) || (state == DATA) || (state == CHK);
  assign tmo_hit  = counting && !stb && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Inter-byte timer: cleared by each byte, runs only while mid-frame.
  always_ff @(posedge clk) begin
    if (rstn) begin
      timer <= {TW{1'b0}};
    end else if (stb || !counting || tmo_hit) begin
      timer <= {TW{1'b0}};
    end else begin
      timer <= timer + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and error decision for the framing FSM.
  always_comb begin
    state_next = state;
    err_fire   = 1'b0;
    err_next   = ERR_NONE;
    case (state)
      HUNT: begin
        if (stb && (rx_data == HEADER)) begin
          state_next = CMD;
        end else begin
          state_next = HUNT;
        end
      end
      CMD: begin
        if (stb) begin
          state_next = LEN;
        end else begin
          state_next = CMD;
        end
      end
      LEN: begin
        if (stb && (rx_data > MAX_LEN_B)) begin
          state_next = HUNT;
          err_fire   = 1'b1;
          err_next   = ERR_LEN;
        end else if (stb && (rx_data == 8'd0)) begin
          state_next = CHK;
        end else if (stb) begin
          state_next = DATA;
        end else begin
          state_next = LEN;
        end
      end
      DATA: begin
        if (stb && ((idx + LW'(1)) == len)) begin
          state_next = CHK;
        end else begin
          state_next = DATA;
        end
      end
      CHK: begin
        if (stb && (rx_data == chk)) begin
          state_next = HOLD;
        end else if (stb) begin
          state_next = HUNT;
          err_fire   = 1'b1;
          err_next   = ERR_CHK;
        end else begin
          state_next = CHK;
        end
      end
      HOLD: begin
        if (pkt_ready) begin
          state_next = HUNT;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
    if (tmo_hit) begin
      state_next = HUNT;
      err_fire   = 1'b1;
      err_next   = ERR_TMO;
    end else begin
      err_fire   = err_fire;
    end
  end

  // State register, edge-detect flop and registered status outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= HUNT;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      rx_en_q    <= 1'b1;
      err_sig_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state      <= state_next;
      done_q     <= rx_done_sig;
      valid_q    <= (state_next == HOLD);
      rx_en_q    <= (state_next != HOLD);
      err_sig_q  <= err_fire;
      if (err_fire) begin
        err_code_q <= err_next;
      end
    end
  end

  // Frame fields, running checksum and payload index, updated on byte strobes.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cmd <= 8'h00;
      len <= {LW{1'b0}};
      idx <= {LW{1'b0}};
      chk <= 8'h00;
    end else if (stb) begin
      case (state)
        CMD: begin
          cmd <= rx_data;
          chk <= rx_data;
        end
        LEN: begin
          len <= rx_data[LW-1:0];
          chk <= chk_xor(chk, rx_data);
          idx <= {LW{1'b0}};
        end
        DATA: begin
          chk <= chk_xor(chk, rx_data);
          idx <= idx + LW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  rx_pkt_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx[AW-1:0]),
    .wdata (rx_data),
    .raddr (pkt_rd_addr),
    .rdata (pkt_rd_data)
  );

  assign pkt_valid = valid_q;
  assign rx_en_sig = rx_en_q;
  assign err_sig   = err_sig_q;
  assign err_code  = err_code_q;
  assign pkt_cmd   = cmd;
  assign pkt_len   = len;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Self-checking bench for rx_packet_parser: directed frames followed by
// randomized frame streams, compared against a queue-based frame model.
module tb_rx_packet_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 100;
  localparam int         LW      = $clog2(MAX_LEN + 1);
  localparam int         AW      = $clog2(MAX_LEN);
  localparam logic [7:0] HDR     = 8'hAA;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_done_sig;
  logic          rx_en_sig;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [7:0]    pkt_cmd;
  logic [LW-1:0] pkt_len;
  logic [AW-1:0] pkt_rd_addr;
  logic [7:0]    pkt_rd_data;
  logic          err_sig;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  rx_packet_parser #(
    .MAX_LEN        (MAX_LEN),
    .HEADER         (HDR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .rx_en_sig   (rx_en_sig),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_cmd     (pkt_cmd),
    .pkt_len     (pkt_len),
    .pkt_rd_addr (pkt_rd_addr),
    .pkt_rd_data (pkt_rd_data),
    .err_sig     (err_sig),
    .err_code    (err_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bytes of the frame in progress (header first).
  logic [7:0] part[$];
  logic [1:0] m_err_code = 2'd0;
  int         m_err_pulses = 0;
  int         err_hi_cycles = 0;

  // Count every cycle err_sig is high; each error must be exactly one cycle.
  always @(negedge clk) begin
    if (err_sig === 1'b1) err_hi_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: returns 1 when a complete, checksum-correct frame sits in part.
  task automatic model_byte(input logic [7:0] b, output bit done);
    logic [7:0] x;
    done = 1'b0;
    if (part.size() == 0) begin
      if (b == HDR) part.push_back(b);
    end else begin
      part.push_back(b);
      if (part.size() == 3 && int'(part[2]) > MAX_LEN) begin
        m_err_code = 2'd1;
        m_err_pulses++;
        part.delete();
      end else if (part.size() >= 4 && part.size() == int'(part[2]) + 4) begin
        x = 8'h00;
        for (int i = 1; i < part.size() - 1; i++) x ^= part[i];
        if (x == part[part.size() - 1]) begin
          done = 1'b1;
        end else begin
          m_err_code = 2'd2;
          m_err_pulses++;
          part.delete();
        end
      end
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    rx_done_sig = 1'b1;
    repeat (2) @(negedge clk);
    rx_done_sig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_held(input string tag);
    check_eq({tag, "_valid"}, 32'(pkt_valid), 32'd1);
    check_eq({tag, "_rx_en"}, 32'(rx_en_sig), 32'd0);
    check_eq({tag, "_cmd"},   32'(pkt_cmd),   32'(part[1]));
    check_eq({tag, "_len"},   32'(pkt_len),   32'(part[2]));
    for (int i = 0; i < int'(part[2]); i++) begin
      pkt_rd_addr = AW'(i);
      #1;
      check_eq({tag, "_rd"}, 32'(pkt_rd_data), 32'(part[3 + i]));
    end
  endtask

  // Send one byte to DUT and model, compare status; service a completed frame.
  task automatic feed(input logic [7:0] b, input int extras);
    bit done;
    drive_byte(b);
    model_byte(b, done);
    check_eq("valid", 32'(pkt_valid), 32'(done));
    check_eq("err_code", 32'(err_code), 32'(m_err_code));
    check_eq("err_pulses", 32'(err_hi_cycles), 32'(m_err_pulses));
    if (done) begin
      check_held("hold");
      if (extras > 0) begin
        for (int k = 0; k < extras; k++) drive_byte(8'($urandom));
        check_held("hold_after_bytes");
        check_eq("hold_err_pulses", 32'(err_hi_cycles), 32'(m_err_pulses));
      end
      @(negedge clk);
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
      check_eq("released_valid", 32'(pkt_valid), 32'd0);
      check_eq("released_rx_en", 32'(rx_en_sig), 32'd1);
      part.delete();
    end
  endtask

  task automatic feed_frame(input logic [7:0] cmd, input int len, input logic [7:0] chk_flip, input int extras);
    logic [7:0] pl[$];
    logic [7:0] x;
    x = cmd ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      pl.push_back(8'($urandom));
      x ^= pl[i];
    end
    feed(HDR, 0);
    feed(cmd, 0);
    feed(8'(len), 0);
    foreach (pl[i]) feed(pl[i], 0);
    feed(x ^ chk_flip, extras);
  endtask

  initial begin
    rstn        = 1'b1;
    rx_data     = 8'h00;
    rx_done_sig = 1'b0;
    pkt_ready   = 1'b0;
    pkt_rd_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(pkt_valid), 32'd0);
    check_eq("rst_rx_en", 32'(rx_en_sig), 32'd1);
    check_eq("rst_err_sig", 32'(err_sig), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);
    check_eq("rst_cmd", 32'(pkt_cmd), 32'd0);
    check_eq("rst_len", 32'(pkt_len), 32'd0);
    rstn = 1'b0;
    @(negedge clk);

    // Directed frames.
    feed(8'hAA, 0); feed(8'h10, 0); feed(8'h02, 0); feed(8'h55, 0); feed(8'h66, 0); feed(8'h21, 0);
    feed(8'h00, 0); feed(8'hFF, 0); feed(8'h13, 0);
    feed(8'hAA, 0); feed(8'h07, 0); feed(8'h00, 0); feed(8'h07, 0);
    feed(8'hAA, 0); feed(8'h01, 0); feed(8'h11, 0);
    feed_frame(8'h3C, 3, 8'h00, 0);
    feed(8'hAA, 0); feed(8'h01, 0); feed(8'h01, 0); feed(8'h33, 0); feed(8'h00, 0);
    feed_frame(8'h42, 4, 8'h00, 3);
    feed_frame(8'h43, MAX_LEN, 8'h00, 0);
    feed_frame(8'h44, 1, 8'h00, 0);
    feed(8'hAA, 0); feed(8'h05, 0); feed(8'h10, 0); feed(8'hAA, 0);
    feed(8'hAA, 0); feed(8'hAA, 0); feed(8'h10, 0);
    feed(8'h10 ^ 8'h05 ^ 8'h10 ^ 8'hAA ^ 8'hAA ^ 8'hAA ^ 8'h10, 0);

    // Reset mid-frame: partial frame lost, no error flagged.
    feed(8'hAA, 0); feed(8'h10, 0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); rstn = 1'b0;
    part.delete();
    m_err_code = 2'd0;
    @(negedge clk);
    check_eq("midrst_err_code", 32'(err_code), 32'd0);
    check_eq("midrst_valid", 32'(pkt_valid), 32'd0);
    check_eq("midrst_pulses", 32'(err_hi_cycles), 32'(m_err_pulses));
    feed_frame(8'h55, 2, 8'h00, 0);

    // Inter-byte timeout behaviour.
    feed(8'hAA, 0); feed(8'h05, 0);
`ifdef RX_PKT_TIMEOUT_EN
    repeat (TMO + 20) @(negedge clk);
    part.delete();
    m_err_code = 2'd3;
    m_err_pulses++;
    check_eq("tmo_err_code", 32'(err_code), 32'd3);
    check_eq("tmo_pulses", 32'(err_hi_cycles), 32'(m_err_pulses));
    feed_frame(8'h66, 0, 8'h00, 0);
`else
    repeat (1000) @(negedge clk);
    check_eq("notmo_err_code", 32'(err_code), 32'(m_err_code));
    check_eq("notmo_pulses", 32'(err_hi_cycles), 32'(m_err_pulses));
    check_eq("notmo_valid", 32'(pkt_valid), 32'd0);
    for (int i = 0; i < 5; i++) feed(8'(i + 1), 0);
    feed(8'h05 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05, 0);
`endif

    // Randomized frame streams.
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 3))
        0: feed_frame(8'($urandom), int'($urandom_range(0, MAX_LEN)), 8'h00, int'($urandom_range(0, 2)));
        1: feed_frame(8'($urandom), int'($urandom_range(0, MAX_LEN)), 8'($urandom_range(1, 255)), 0);
        2: begin
          feed(HDR, 0);
          feed(8'($urandom), 0);
          feed(8'($urandom_range(MAX_LEN + 1, 255)), 0);
        end
        default: begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) feed(8'($urandom), 0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
